// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU datapath widths and reset PC
package cpu_pkg;
   localparam int PC_W     = 10;
   localparam int INSTR_W  = 16;
   localparam int RESET_PC = 0;
endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO with flush, occupancy count and same-cycle push/pop
module fetch_fifo #(
   parameter  int WIDTH = 26,
   parameter  int DEPTH = 2,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic [CNT_W-1:0] count
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      do_pop   = pop && (count_q != '0);
      // A full FIFO may still accept a push when the head leaves the same cycle.
      do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
         end
         if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end
         count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   assign rdata = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
   assign count = count_q;
endmodule

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch front end: next-PC, imem requests, PC-tagged fetch FIFO
module ifetch_unit #(
   parameter int PC_W    = cpu_pkg::PC_W,
   parameter int INSTR_W = cpu_pkg::INSTR_W,
   parameter int DEPTH   = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [PC_W-1:0]    pc_out,
   output logic [PC_W-1:0]    pc_in,
   output logic               imem_req_valid,
   input  logic               imem_req_ready,
   output logic [PC_W-1:0]    imem_req_addr,
   input  logic               imem_rsp_valid,
   input  logic [INSTR_W-1:0] imem_rsp_data,
   input  logic               redirect_valid,
   input  logic [PC_W-1:0]    redirect_pc,
   input  logic               halt,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic [INSTR_W-1:0] instr_data,
   output logic [PC_W-1:0]    instr_pc
);
   import cpu_pkg::*;

   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [CNT_W-1:0]        outstanding_q, outstanding_d;
   logic [CNT_W-1:0]        drop_q, drop_d;
   logic [CNT_W-1:0]        fifo_count;
   logic [PC_W-1:0]         dpc_q, dpc_d;
   logic                    fire, rsp_ok, push, pop;
   logic [INSTR_W+PC_W-1:0] head;

   assign instr_valid   = (fifo_count != '0);
   assign instr_data    = head[INSTR_W+PC_W-1:PC_W];
   assign instr_pc      = head[PC_W-1:0];
   assign imem_req_addr = pc_out;

   always_comb begin
      // Requests in flight plus buffered entries never exceed DEPTH, so pushes cannot overflow.
      imem_req_valid = reset && !halt && !redirect_valid &&
                       (((CNT_W+1)'(outstanding_q) + (CNT_W+1)'(fifo_count)) < (CNT_W+1)'(DEPTH));
      fire          = imem_req_valid && imem_req_ready;
      rsp_ok        = imem_rsp_valid && (outstanding_q != '0);
      push          = rsp_ok && (drop_q == '0) && !redirect_valid;
      pop           = instr_valid && instr_ready;
      outstanding_d = outstanding_q + CNT_W'(fire) - CNT_W'(rsp_ok);
      drop_d        = drop_q;
      dpc_d         = dpc_q;
      if (redirect_valid) begin
         drop_d = outstanding_q - CNT_W'(rsp_ok);
         dpc_d  = redirect_pc;
      end else begin
         if (rsp_ok && (drop_q != '0)) begin
            drop_d = drop_q - CNT_W'(1);
         end
         if (push) begin
            dpc_d = dpc_q + PC_W'(1);
         end
      end
      if (!reset) begin
         pc_in = PC_W'(RESET_PC);
      end else if (redirect_valid) begin
         pc_in = redirect_pc;
      end else if (fire) begin
         pc_in = pc_out + PC_W'(1);
      end else begin
         pc_in = pc_out;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         outstanding_q <= '0;
         drop_q        <= '0;
         dpc_q         <= PC_W'(RESET_PC);
      end else begin
         outstanding_q <= outstanding_d;
         drop_q        <= drop_d;
         dpc_q         <= dpc_d;
      end
   end

   fetch_fifo #(
      .WIDTH (INSTR_W + PC_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (reset),
      .flush (redirect_valid),
      .push  (push),
      .wdata ({imem_rsp_data, dpc_q}),
      .pop   (pop),
      .rdata (head),
      .count (fifo_count)
   );
endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - bench for ifetch_unit: PC register, in-order memory model, scoreboard
module tb_ifetch_unit;
   import cpu_pkg::*;

   localparam int DEPTH = 2;

   logic               clk = 1'b0;
   logic               reset;
   logic [PC_W-1:0]    pc_out, pc_in, imem_req_addr, redirect_pc, instr_pc;
   logic               imem_req_valid, imem_req_ready, imem_rsp_valid;
   logic [INSTR_W-1:0] imem_rsp_data, instr_data;
   logic               redirect_valid, halt, instr_valid, instr_ready;

   always #5 clk = ~clk;

   ifetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .reset          (reset),
      .pc_out         (pc_out),
      .pc_in          (pc_in),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt           (halt),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr_data     (instr_data),
      .instr_pc       (instr_pc)
   );

   typedef struct {
      logic [PC_W-1:0] addr;
      int              due;
      int              epoch;
   } mreq_t;

   typedef struct {
      logic [INSTR_W-1:0] data;
      logic [PC_W-1:0]    pc;
   } exp_t;

   typedef struct {
      logic [PC_W-1:0] pc;
      logic            hlt;
      logic            rv;
      logic [PC_W-1:0] rpc;
      logic            rdy;
      logic            exp_v;
      logic [PC_W-1:0] exp_pc;
   } vec_t;

   mreq_t           mq[$];
   exp_t            sb[$];
   vec_t            vt[6];
   int              checks = 0;
   int              errors = 0;
   int              cyc = 0;
   int              epoch = 0;
   int              lat = 1;
   int              first_fire, first_valid, delivered;
   logic [PC_W-1:0] pc_reg, first_pc;
   logic            wrap_seen;

   function automatic logic [INSTR_W-1:0] mdata(input logic [PC_W-1:0] a);
      return INSTR_W'(a) ^ 16'hA5A5;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic do_reset();
      reset          = 1'b0;
      halt           = 1'b0;
      instr_ready    = 1'b0;
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      pc_out         = 10'h155;
      mq.delete();
      sb.delete();
      epoch  = 0;
      pc_reg = '0;
      repeat (2) @(negedge clk);
      chk("rst_req_valid", imem_req_valid, 0);
      chk("rst_instr_valid", instr_valid, 0);
      chk("rst_pc_in", pc_in, 0);
      chk("rst_instr_pc", instr_pc, 0);
      chk("rst_instr_data", instr_data, 0);
      halt        = 1'b1;
      reset       = 1'b1;
      cyc         = 0;
      first_fire  = -1;
      first_valid = -1;
      delivered   = 0;
      wrap_seen   = 1'b0;
   endtask

   // One clock cycle: drive inputs at the falling edge, sample 1 time unit later, commit at the rising edge.
   task automatic step(input logic rv, input logic [PC_W-1:0] rpc);
      logic            rsp, fire, exp_v;
      logic [PC_W-1:0] exp_pc, nxt;
      exp_t            e;
      pc_out         = pc_reg;
      redirect_valid = rv;
      redirect_pc    = rpc;
      rsp            = (mq.size() > 0) && (mq[0].due <= cyc);
      imem_rsp_valid = rsp;
      imem_rsp_data  = rsp ? mdata(mq[0].addr) : '0;
      exp_v          = !halt && !rv && ((mq.size() + sb.size()) < DEPTH);
      #1;
      if (rsp) chk("proto_outstanding_nonzero", (dut.outstanding_q != '0), 1);
      chk("req_valid", imem_req_valid, exp_v);
      chk("instr_valid", instr_valid, (sb.size() > 0));
      fire   = imem_req_valid && imem_req_ready;
      exp_pc = rv ? rpc : ((exp_v && imem_req_ready) ? pc_reg + 1'b1 : pc_reg);
      chk("pc_in", pc_in, exp_pc);
      if (fire) chk("req_addr", imem_req_addr, pc_reg);
      if (fire && pc_reg == 10'h3FF) wrap_seen = 1'b1;
      if (instr_valid && first_valid < 0) first_valid = cyc;
      if (instr_valid && instr_ready && sb.size() > 0) begin
         e = sb.pop_front();
         chk("instr_pc", instr_pc, e.pc);
         chk("instr_data", instr_data, e.data);
         if (delivered == 0) first_pc = instr_pc;
         delivered++;
      end
      if (rsp) begin
         if (mq[0].epoch == epoch && !rv) sb.push_back('{mdata(mq[0].addr), mq[0].addr});
         void'(mq.pop_front());
      end
      if (fire) begin
         mq.push_back('{pc_reg, cyc + lat, epoch});
         if (first_fire < 0) first_fire = cyc;
      end
      if (rv) begin
         epoch++;
         sb.delete();
      end
      nxt = pc_in;
      @(posedge clk);
      pc_reg = nxt;
      cyc++;
      @(negedge clk);
   endtask

   task automatic drain();
      int n = 0;
      halt        = 1'b1;
      instr_ready = 1'b1;
      while ((mq.size() > 0 || sb.size() > 0) && n < 40) begin
         step(1'b0, '0);
         n++;
      end
      chk("drained", (mq.size() == 0 && sb.size() == 0), 1);
      chk("idle_instr_valid", instr_valid, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vt[0] = '{10'h005, 1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 10'h006};
      vt[1] = '{10'h005, 1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 10'h005};
      vt[2] = '{10'h3FF, 1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 10'h000};
      vt[3] = '{10'h3FF, 1'b1, 1'b0, 10'h000, 1'b1, 1'b0, 10'h3FF};
      vt[4] = '{10'h010, 1'b0, 1'b1, 10'h200, 1'b1, 1'b0, 10'h200};
      vt[5] = '{10'h010, 1'b1, 1'b1, 10'h155, 1'b0, 1'b0, 10'h155};

      do_reset();

      // Combinational next-PC / issue vectors from the idle state; inputs are parked before each rising edge.
      for (int i = 0; i < 6; i++) begin
         pc_out         = vt[i].pc;
         halt           = vt[i].hlt;
         redirect_valid = vt[i].rv;
         redirect_pc    = vt[i].rpc;
         imem_req_ready = vt[i].rdy;
         #1;
         chk($sformatf("vec%0d_req_valid", i), imem_req_valid, vt[i].exp_v);
         chk($sformatf("vec%0d_pc_in", i), pc_in, vt[i].exp_pc);
         chk($sformatf("vec%0d_req_addr", i), imem_req_addr, vt[i].pc);
         halt           = 1'b1;
         redirect_valid = 1'b0;
         imem_req_ready = 1'b1;
         @(negedge clk);
      end

      // 1: streaming with 1-cycle memory latency
      halt        = 1'b0;
      instr_ready = 1'b1;
      lat         = 1;
      repeat (12) step(1'b0, '0);
      chk("t1_first_valid_latency", first_valid - first_fire, 2);
      chk("t1_progress", (delivered >= 6), 1);
      drain();

      // 2: decode stalled, then released
      do_reset();
      halt        = 1'b0;
      instr_ready = 1'b0;
      repeat (4) step(1'b0, '0);
      pc_out = pc_reg;
      #1;
      chk("t2_stall_req_valid", imem_req_valid, 0);
      chk("t2_stall_pc_in", pc_in, 10'h002);
      instr_ready = 1'b1;
      repeat (8) step(1'b0, '0);
      chk("t2_first_pc", first_pc, 10'h000);
      drain();

      // 3: redirect with two stale requests in flight
      halt        = 1'b0;
      instr_ready = 1'b1;
      lat         = 3;
      repeat (2) step(1'b0, '0);
      step(1'b1, 10'h200);
      delivered = 0;
      repeat (12) step(1'b0, '0);
      chk("t3_first_pc_after_redirect", first_pc, 10'h200);
      drain();

      // 4: redirect coincides with a response and a pop of the only FIFO entry
      halt        = 1'b0;
      instr_ready = 1'b0;
      lat         = 1;
      repeat (2) step(1'b0, '0);
      instr_ready = 1'b1;
      step(1'b1, 10'h100);
      chk("t4_fifo_flushed", instr_valid, 0);
      chk("t4_drop_cnt", dut.drop_q, 0);
      chk("t4_outstanding", dut.outstanding_q, 0);
      delivered = 0;
      repeat (8) step(1'b0, '0);
      chk("t4_first_pc_after_redirect", first_pc, 10'h100);
      drain();

      // 5: halt with two outstanding, then PC wrap through 0x3FF
      halt        = 1'b0;
      instr_ready = 1'b1;
      lat         = 3;
      repeat (2) step(1'b0, '0);
      halt      = 1'b1;
      delivered = 0;
      repeat (6) step(1'b0, '0);
      chk("t5_halt_delivered", delivered, 2);
      halt = 1'b0;
      lat  = 1;
      step(1'b1, 10'h3FE);
      delivered = 0;
      repeat (8) step(1'b0, '0);
      chk("t5_wrap_seen", wrap_seen, 1);
      chk("t5_wrap_progress", (delivered >= 3), 1);
      drain();

      // 6: asynchronous reset with the FIFO full
      halt        = 1'b0;
      instr_ready = 1'b0;
      lat         = 1;
      repeat (4) step(1'b0, '0);
      chk("t6_fifo_full", dut.u_fifo.count_q, 2);
      pc_out = pc_reg;
      #2;
      reset = 1'b0;
      #1;
      chk("t6_async_instr_valid", instr_valid, 0);
      chk("t6_async_req_valid", imem_req_valid, 0);
      chk("t6_async_pc_in", pc_in, 0);
      do_reset();
      halt        = 1'b0;
      instr_ready = 1'b1;
      repeat (8) step(1'b0, '0);
      chk("t6_restart_first_fire", first_fire, 0);
      chk("t6_restart_first_pc", first_pc, 10'h000);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
